// File: rtl/fetch_seq_ctrl_pkg.sv
// Shared definitions for the halfword fetch sequencer: FSM state encoding
// and the halfword step applied per assembled instruction length.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_STALL = 3'd2,
        ST_FLUSH = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_e;

    localparam int HW_STEP16 = 1;
    localparam int HW_STEP32 = 2;

    function automatic int hw_step(input logic len16);
        return len16 ? HW_STEP16 : HW_STEP32;
    endfunction

endpackage

// File: rtl/fetch_seq_ctrl_if.sv
// Handshake bundle between the fetch sequencer (master) and the
// branch/decode + inst_fetch/instruction-memory environment (slave).
interface fetch_seq_ctrl_if #(
    parameter int ADDR_WIDTH = 6
);

    logic                  stall;
    logic                  redir_valid;
    logic [ADDR_WIDTH-1:0] redir_addr;
    logic                  asm_valid;
    logic                  asm_len16;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_en;
    logic                  asm_hold;
    logic                  asm_flush;
    logic [ADDR_WIDTH-1:0] inst_pc;
    logic                  inst_pc_valid;
    logic                  halted;

    modport master (
        input  stall,
        input  redir_valid,
        input  redir_addr,
        input  asm_valid,
        input  asm_len16,
        output mem_addr,
        output mem_en,
        output asm_hold,
        output asm_flush,
        output inst_pc,
        output inst_pc_valid,
        output halted
    );

    modport slave (
        output stall,
        output redir_valid,
        output redir_addr,
        output asm_valid,
        output asm_len16,
        input  mem_addr,
        input  mem_en,
        input  asm_hold,
        input  asm_flush,
        input  inst_pc,
        input  inst_pc_valid,
        input  halted
    );

endinterface

// File: rtl/fetch_seq_ctrl_pc_track.sv
// Start-PC tracker: holds the halfword address of the instruction the
// assembler is currently building and gates its valid into inst_pc_valid.
module fetch_pc_track
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int RESET_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  track_en,
    input  logic                  asm_valid,
    input  logic                  asm_len16,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_pc_valid
);

    logic [ADDR_WIDTH-1:0] start_pc;
    logic [ADDR_WIDTH-1:0] step;

    assign step          = ADDR_WIDTH'(hw_step(asm_len16));
    assign inst_pc       = start_pc;
    assign inst_pc_valid = asm_valid & track_en;

    // A redirect wins over an instruction completing in the same cycle:
    // that instruction is still reported at the old start_pc.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_pc <= ADDR_WIDTH'(RESET_ADDR);
        end else if (load) begin
            start_pc <= load_addr;
        end else if (inst_pc_valid) begin
            start_pc <= start_pc + step;
        end
    end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Halfword fetch sequencer: FSM, memory address counter and assembler control.
// Optional macro FETCH_SEQ_PERF_CNT_EN adds saturating instruction/stall counters.
module fetch_seq_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int RESET_ADDR = 0,
    parameter int END_ADDR   = 36
) (
    input  logic             clk,
    input  logic             rst,
    fetch_seq_ctrl_if.master bus
`ifdef FETCH_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]      perf_inst_cnt,
    output logic [15:0]      perf_stall_cnt
`endif
);

    localparam logic [ADDR_WIDTH-1:0] RESET_A = ADDR_WIDTH'(RESET_ADDR);
    localparam logic [ADDR_WIDTH-1:0] END_A   = ADDR_WIDTH'(END_ADDR);

    fetch_state_e          state;
    fetch_state_e          state_next;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  mem_en;
    logic                  asm_hold;
    logic                  asm_flush;
    logic                  halted;
    logic                  redir_take;
    logic                  track_en;
    logic                  inst_pc_valid;
    logic [ADDR_WIDTH-1:0] inst_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_INIT;
            mem_addr_q <= RESET_A;
        end else begin
            state      <= state_next;
            mem_addr_q <= addr_next;
        end
    end

    // Priority inside each state: redirect, then program end, then stall.
    always_comb begin
        state_next = state;
        addr_next  = mem_addr_q;
        mem_en     = 1'b0;
        asm_hold   = 1'b1;
        asm_flush  = 1'b0;
        halted     = 1'b0;
        redir_take = 1'b0;

        case (state)
            ST_INIT: begin
                asm_flush  = 1'b1;
                state_next = ST_FETCH;
            end

            ST_FETCH: begin
                asm_hold = 1'b0;
                mem_en   = ~bus.stall;
                if (bus.redir_valid) begin
                    redir_take = 1'b1;
                end else if (mem_en && (mem_addr_q == END_A)) begin
                    state_next = ST_HALT;
                end else if (bus.stall) begin
                    state_next = ST_STALL;
                end else begin
                    addr_next = mem_addr_q + ADDR_WIDTH'(1);
                end
            end

            ST_STALL: begin
                if (bus.redir_valid) begin
                    redir_take = 1'b1;
                end else if (!bus.stall) begin
                    state_next = ST_FETCH;
                end
            end

            ST_FLUSH: begin
                asm_flush = 1'b1;
                asm_hold  = 1'b0;
                if (bus.redir_valid) begin
                    redir_take = 1'b1;
                end else if (bus.stall) begin
                    state_next = ST_STALL;
                end else begin
                    state_next = ST_FETCH;
                end
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_next = ST_INIT;
            end
        endcase

        if (redir_take) begin
            addr_next  = bus.redir_addr;
            state_next = ST_FLUSH;
        end
    end

    // Instructions are only reported while the assembler is live; the
    // FLUSH cycle swallows whatever it produces.
    assign track_en = (state == ST_FETCH) || (state == ST_STALL);

    fetch_pc_track #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_ADDR (RESET_ADDR)
    ) u_pc_track (
        .clk           (clk),
        .rst           (rst),
        .track_en      (track_en),
        .asm_valid     (bus.asm_valid),
        .asm_len16     (bus.asm_len16),
        .load          (redir_take),
        .load_addr     (bus.redir_addr),
        .inst_pc       (inst_pc),
        .inst_pc_valid (inst_pc_valid)
    );

    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_en        = mem_en;
    assign bus.asm_hold      = asm_hold;
    assign bus.asm_flush     = asm_flush;
    assign bus.halted        = halted;
    assign bus.inst_pc       = inst_pc;
    assign bus.inst_pc_valid = inst_pc_valid;

`ifdef FETCH_SEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_inst_cnt  <= 16'h0000;
            perf_stall_cnt <= 16'h0000;
        end else begin
            if (inst_pc_valid && (perf_inst_cnt != 16'hFFFF)) begin
                perf_inst_cnt <= perf_inst_cnt + 16'h0001;
            end
            if ((state == ST_STALL) && (perf_stall_cnt != 16'hFFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed, table-driven bench for fetch_seq_ctrl plus hand-written
// sequences for program end, halt and restart.
module tb_fetch_seq_ctrl;

    localparam int AW = 6;
    localparam int NV = 29;

    typedef struct packed {
        logic          stall;
        logic          redir;
        logic [AW-1:0] raddr;
        logic          av;
        logic          l16;
        logic [AW-1:0] e_addr;
        logic          e_en;
        logic          e_hold;
        logic          e_flush;
        logic [AW-1:0] e_pc;
        logic          e_pcv;
        logic          e_halt;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs [NV];

    fetch_seq_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

`ifdef FETCH_SEQ_PERF_CNT_EN
    logic [15:0] perf_inst_cnt;
    logic [15:0] perf_stall_cnt;
`endif

    fetch_seq_ctrl #(
        .ADDR_WIDTH (AW),
        .RESET_ADDR (0),
        .END_ADDR   (36)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_SEQ_PERF_CNT_EN
        ,
        .perf_inst_cnt  (perf_inst_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input int st, input int rv, input int ra, input int av,
                                input int l16, input int ea, input int een, input int eh,
                                input int ef, input int epc, input int epv, input int eha);
        vec_t v;
        v.stall   = st[0];
        v.redir   = rv[0];
        v.raddr   = AW'(ra);
        v.av      = av[0];
        v.l16     = l16[0];
        v.e_addr  = AW'(ea);
        v.e_en    = een[0];
        v.e_hold  = eh[0];
        v.e_flush = ef[0];
        v.e_pc    = AW'(epc);
        v.e_pcv   = epv[0];
        v.e_halt  = eha[0];
        return v;
    endfunction

    task automatic checkField(input string name, input int idx,
                              input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.stall       = v.stall;
        bus.redir_valid = v.redir;
        bus.redir_addr  = v.raddr;
        bus.asm_valid   = v.av;
        bus.asm_len16   = v.l16;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkField("mem_addr",      idx, 32'(bus.mem_addr),      32'(v.e_addr));
        checkField("mem_en",        idx, 32'(bus.mem_en),        32'(v.e_en));
        checkField("asm_hold",      idx, 32'(bus.asm_hold),      32'(v.e_hold));
        checkField("asm_flush",     idx, 32'(bus.asm_flush),     32'(v.e_flush));
        checkField("inst_pc",       idx, 32'(bus.inst_pc),       32'(v.e_pc));
        checkField("inst_pc_valid", idx, 32'(bus.inst_pc_valid), 32'(v.e_pcv));
        checkField("halted",        idx, 32'(bus.halted),        32'(v.e_halt));
    endtask

    // Two reset edges; outputs are checked while reset is still asserted.
    task automatic resetDut(input int tag);
        rst = 1'b1;
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        #1;
        checkOutput(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;

        //              st rv ra av l16  addr en hd fl  pc pcv ht
        vecs[0]  = mk(0, 0, 0,  0, 0,   0, 0, 1, 1,  0, 0, 0);
        vecs[1]  = mk(0, 0, 0,  0, 0,   0, 1, 0, 0,  0, 0, 0);
        vecs[2]  = mk(0, 0, 0,  1, 1,   1, 1, 0, 0,  0, 1, 0);
        vecs[3]  = mk(0, 0, 0,  0, 0,   2, 1, 0, 0,  1, 0, 0);
        vecs[4]  = mk(0, 0, 0,  1, 0,   3, 1, 0, 0,  1, 1, 0);
        vecs[5]  = mk(0, 0, 0,  1, 1,   4, 1, 0, 0,  3, 1, 0);
        vecs[6]  = mk(1, 0, 0,  0, 0,   5, 0, 0, 0,  4, 0, 0);
        vecs[7]  = mk(1, 0, 0,  0, 0,   5, 0, 1, 0,  4, 0, 0);
        vecs[8]  = mk(1, 0, 0,  0, 0,   5, 0, 1, 0,  4, 0, 0);
        vecs[9]  = mk(0, 0, 0,  0, 0,   5, 0, 1, 0,  4, 0, 0);
        vecs[10] = mk(0, 0, 0,  0, 0,   5, 1, 0, 0,  4, 0, 0);
        vecs[11] = mk(0, 0, 0,  1, 1,   6, 1, 0, 0,  4, 1, 0);
        vecs[12] = mk(0, 1, 20, 0, 0,   7, 1, 0, 0,  5, 0, 0);
        vecs[13] = mk(0, 0, 0,  1, 1,  20, 0, 0, 1, 20, 0, 0);
        vecs[14] = mk(0, 0, 0,  0, 0,  20, 1, 0, 0, 20, 0, 0);
        vecs[15] = mk(0, 0, 0,  1, 1,  21, 1, 0, 0, 20, 1, 0);
        vecs[16] = mk(1, 1, 10, 0, 0,  22, 0, 0, 0, 21, 0, 0);
        vecs[17] = mk(1, 0, 0,  0, 0,  10, 0, 0, 1, 10, 0, 0);
        vecs[18] = mk(1, 0, 0,  0, 0,  10, 0, 1, 0, 10, 0, 0);
        vecs[19] = mk(0, 0, 0,  1, 0,  10, 0, 1, 0, 10, 1, 0);
        vecs[20] = mk(0, 0, 0,  0, 0,  10, 1, 0, 0, 12, 0, 0);
        vecs[21] = mk(0, 1, 30, 1, 1,  11, 1, 0, 0, 12, 1, 0);
        vecs[22] = mk(0, 0, 0,  0, 0,  30, 0, 0, 1, 30, 0, 0);
        vecs[23] = mk(0, 0, 0,  0, 0,  30, 1, 0, 0, 30, 0, 0);
        vecs[24] = mk(0, 1, 62, 0, 0,  31, 1, 0, 0, 30, 0, 0);
        vecs[25] = mk(0, 0, 0,  0, 0,  62, 0, 0, 1, 62, 0, 0);
        vecs[26] = mk(0, 0, 0,  0, 0,  62, 1, 0, 0, 62, 0, 0);
        vecs[27] = mk(0, 0, 0,  1, 0,  63, 1, 0, 0, 62, 1, 0);
        vecs[28] = mk(0, 0, 0,  1, 1,   0, 1, 0, 0,  0, 1, 0);

        $display("[TB] reset and table vectors");
        resetDut(100);
        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput(vecs[i], i);
            @(negedge clk);
        end

        // Free run to program end; a redirect during INIT must be ignored.
        $display("[TB] free run to program end");
        resetDut(200);
        applyStimulus(mk(0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        checkOutput(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), 201);
        @(negedge clk);
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int a = 0; a <= 36; a++) begin
            #1;
            checkField("run_addr",   a, 32'(bus.mem_addr), 32'(a));
            checkField("run_en",     a, 32'(bus.mem_en),   32'd1);
            checkField("run_halted", a, 32'(bus.halted),   32'd0);
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                applyStimulus(mk(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            end else begin
                applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            end
            #1;
            checkField("halt_halted", 300 + k, 32'(bus.halted),    32'd1);
            checkField("halt_en",     300 + k, 32'(bus.mem_en),    32'd0);
            checkField("halt_hold",   300 + k, 32'(bus.asm_hold),  32'd1);
            checkField("halt_flush",  300 + k, 32'(bus.asm_flush), 32'd0);
            @(negedge clk);
        end

        $display("[TB] restart from halt");
        resetDut(400);
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        checkOutput(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), 401);
        @(negedge clk);
        #1;
        checkOutput(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 402);
        @(negedge clk);
        #1;
        checkOutput(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), 403);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_seq_ctrl.md
Name: fetch_seq_ctrl

Overview:
- Sequences the halfword instruction fetch path: drives the instruction-memory halfword address and read enable.
- Controls the halfword assembler (inst_fetch) with hold and flush.
- Tracks the start PC of each assembled instruction from the assembler's valid and length outputs.
- Sits between branch/decode logic and the inst_fetch + instruction-memory pair.

Parameters:
ADDR_WIDTH, 6, halfword address width (memory depth 1<<ADDR_WIDTH)
RESET_ADDR, 0, halfword address fetched first after reset
END_ADDR, 36, halfword address at which fetch halts (program end)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
stall  input  1  downstream not ready; freeze fetch
redir_valid  input  1  branch redirect request, single-cycle pulse
redir_addr  input  ADDR_WIDTH  redirect target halfword address
asm_valid  input  1  inst_fetch valid (complete instruction this cycle)
asm_len16  input  1  inst_fetch is_inst_len_16 qualifier
mem_addr  output  ADDR_WIDTH  halfword read address to instruction memory (combinational read)
mem_en  output  1  halfword on mem data is consumed by assembler this cycle
asm_hold  output  1  assembler must hold its state
asm_flush  output  1  assembler must discard partial instruction
inst_pc  output  ADDR_WIDTH  start halfword address of instruction reported by asm_valid
inst_pc_valid  output  1  equals asm_valid while in FETCH/STALL; 0 otherwise
halted  output  1  fetch reached END_ADDR

Behaviour:
- Reset (rst=1 at a clock edge, from any state, including mid-instruction):
  - state=INIT; mem_addr=RESET_ADDR; start_pc=RESET_ADDR.
  - mem_en=0, asm_hold=1, asm_flush=1, halted=0, inst_pc_valid=0.
- States:
  - INIT: one cycle; asm_flush=1; mem_en=0; go to FETCH.
  - FETCH: mem_en=1, asm_hold=0; mem_addr increments by 1 each cycle, wrapping at 2^ADDR_WIDTH.
  - STALL: mem_en=0, asm_hold=1; mem_addr is frozen.
  - FLUSH: one cycle; asm_flush=1, mem_en=0; mem_addr already holds the target.
  - HALT: mem_en=0, asm_hold=1, halted=1; only rst exits.
- Transition priority each cycle: rst > redir_valid > END_ADDR reached > stall > normal.
  - redir_valid in FETCH/STALL/FLUSH: next mem_addr=redir_addr, start_pc=redir_addr, next state FLUSH. Ignored in HALT and INIT.
  - FETCH with mem_addr==END_ADDR and mem_en=1: that halfword is consumed; next state HALT.
  - FETCH with stall=1: the current halfword is not consumed (mem_en=0 combinationally); next state STALL.
  - STALL with stall=0: back to FETCH; the same address is re-presented.
- Latency: redirect to first target halfword consumed is 2 cycles (FLUSH, then FETCH). Stall release to resumed consumption is 1 cycle.
- PC tracking:
  - inst_pc = start_pc (combinational).
  - On asm_valid=1 and not flushing: start_pc += asm_len16 ? 1 : 2, modulo 2^ADDR_WIDTH.
  - asm_valid arriving in the FLUSH cycle is suppressed (inst_pc_valid=0) and does not advance start_pc.
- Simultaneous asm_valid and redir_valid: the instruction is reported with the old start_pc, then start_pc loads redir_addr.
- Redirect with a 32-bit instruction half-assembled: the partial instruction is discarded via asm_flush, with no inst_pc_valid.

Optional Feature:
- Macro FETCH_SEQ_PERF_CNT_EN.
- When defined: adds outputs perf_inst_cnt (16b) and perf_stall_cnt (16b).
  - perf_inst_cnt increments on inst_pc_valid; perf_stall_cnt increments per cycle in STALL.
  - Both saturate at 16'hFFFF and reset to 0 on rst.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg: state encoding constants (ST_INIT, ST_FETCH, ST_STALL, ST_FLUSH, ST_HALT, 3-bit), halfword step constants HW_STEP16=1, HW_STEP32=2.
- One natural sub-module: fetch_pc_track (start_pc register and inst_pc_valid gating). The FSM and mem_addr counter stay in the top.

Test Plan:
- Reset: rst high for 2 cycles, release -> INIT 1 cycle with asm_flush=1, then mem_addr 0,1,2,... with mem_en=1; inst_pc_valid=0 until first asm_valid.
- Mixed lengths: asm_valid with len16=1, then len16=0 (spanning 2 cycles), then len16=1 -> inst_pc reported 0, 1, 3.
- Stall: stall=1 for 3 cycles at mem_addr=5 -> mem_addr stays 5, mem_en=0, asm_hold=1; after release mem_en=1 at addr 5, then 6.
- Redirect: redir_valid with redir_addr=20 while the second half of a 32-bit instruction is pending -> next cycle FLUSH (asm_flush=1, mem_addr=20, no inst_pc_valid); following cycle consumes addr 20; next inst_pc=20.
- Redirect during stall: stall=1 and redir_valid=1, addr=10 -> FLUSH taken; with stall still 1 afterwards, state goes to STALL holding addr 10.
- End: free-run from 0 -> addr 36 consumed, then halted=1, mem_en=0 permanently; a later redir_valid is ignored; rst restarts at 0.
